iop_id_stage: RTL and testbench
===============================

IOP_ID_STAGE -- requirements
Module: iop_id_stage

Interface
REQ-001 SHALL have no parameters; data width is fixed at 8 bits and instruction width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  stage can accept; equals (!out_valid | out_ready).
REQ-006 in_instr  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8.
REQ-007 wb_en / wb_addr / wb_data  input  1/3/8  register-file write port from writeback.
REQ-008 flush  input  1  branch taken; kills held and incoming instruction.
REQ-009 out_valid  output  1  registered ALU operand bundle is valid.
REQ-010 out_ready  input  1  ALU/writeback consumes the bundle.
REQ-011 ds1, ds2, imm  output  8 each  registered ALU operands.
REQ-012 alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_sr, alu_sl, alu_sra, alu_slt, alu_eq, alu_neq, unsign, bra  output  1 each  registered one-hot ALU controls.
REQ-013 rd_addr / rd_we  output  3/1  destination forwarded to writeback.
REQ-014 illegal  output  1  registered; opcode 0xE or 0xF.

Function
REQ-015 Opcode map SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SRL (alu_sr, unsign=1), 6 SLL (alu_sl), 7 SRA (alu_sr and alu_sra, unsign=0), 8 SLT, 9 EQ, A NEQ, B SLTU (alu_slt, unsign=1), C LI, D BRA.
REQ-016 imm SHALL be 0 for every opcode except LI, which drives imm=imm8, ds1=ds2=0, and no ALU control.
REQ-017 BRA SHALL drive bra=1, ds1=R[rs1], rd_we=0; all other ALU controls 0.
REQ-018 rd_we SHALL be 1 for opcodes 0x0–0xC with rd≠0, and 0 otherwise.
REQ-019 Opcodes E/F SHALL issue with all controls 0, rd_we=0, illegal=1.
REQ-020 Register file: 8x8, R0 reads 0, writes to R0 ignored; write on clk edge when wb_en.
REQ-021 Transfer in SHALL occur when in_valid & in_ready & !flush; bundle registered with 1-cycle latency.
REQ-022 When out_valid & !out_ready & !flush, all outputs SHALL hold stable.
REQ-023 flush SHALL clear out_valid next cycle and drop in_instr that cycle; flush has priority over all transfers.
REQ-024 When out_valid & out_ready with no new transfer, out_valid SHALL clear next cycle.
REQ-025 Operand regs SHALL be captured only at transfer; controls SHALL be 0 whenever out_valid=0.

Reset
REQ-026 On rst_n low SHALL asynchronously clear out_valid, all controls, ds1, ds2, imm, rd_addr, rd_we, illegal, and R1–R7 to 0.
REQ-027 Reset mid-transfer SHALL discard the instruction; in_ready=1 on first cycle after release.

Configuration
REQ-028 Macro IOP_ID_BYPASS_EN defined: a read of register n in the cycle wb_en writes n (n≠0) SHALL return wb_data.
REQ-029 IOP_ID_BYPASS_EN undefined: same-cycle read SHALL return the old register value; hazard is software's responsibility.

Structure
REQ-030 Opcode constants and the control-bundle struct SHALL live in shared package iop_pkg.
REQ-031 Register file SHALL be sub-module iop_regfile (two async read ports, one sync write port); decode logic stays in iop_id_stage.

Verification
REQ-032 Reset, R2=5, R3=3, instr 0x1498 (SUB r2,r2,r3) -> next cycle out_valid=1, alu_sub=1, ds1=5, ds2=3, rd_addr=2, rd_we=1, imm=0.
REQ-033 LI r1,0xA5 (0xC2A5) -> imm=0xA5, ds1=ds2=0, all controls 0, rd_we=1.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> next instruction issued next cycle.
REQ-035 flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, neither instruction issued.
REQ-036 wb_en=1, wb_addr=4, wb_data=0x7E while reading rs1=4 -> ds1=0x7E with IOP_ID_BYPASS_EN, old R4 without.
REQ-037 Opcodes 7, B, E -> SRA: alu_sr=alu_sra=1, unsign=0; SLTU: alu_slt=1, unsign=1; E: illegal=1, rd_we=0.

Source files
------------

// File: rtl/iop_pkg.sv
// Shared definitions for the IOP instruction-decode stage.
// Holds the opcode map, the field widths and the registered control bundle.
package iop_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 16;
  localparam int RADDR_W = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SRL  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_SLT  = 4'h8,
    OP_EQ   = 4'h9,
    OP_NEQ  = 4'hA,
    OP_SLTU = 4'hB,
    OP_LI   = 4'hC,
    OP_BRA  = 4'hD
  } opcode_e;

  // One-hot ALU controls plus the writeback/illegal flags issued with them.
  typedef struct packed {
    logic alu_add;
    logic alu_sub;
    logic alu_and;
    logic alu_or;
    logic alu_xor;
    logic alu_sr;
    logic alu_sl;
    logic alu_sra;
    logic alu_slt;
    logic alu_eq;
    logic alu_neq;
    logic unsign;
    logic bra;
    logic rd_we;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/iop_regfile.sv
// 8x8 register file: two asynchronous read ports, one synchronous write port.
// R0 always reads 0 and ignores writes.
// Build option IOP_ID_BYPASS_EN: a read of the register being written in the
// same cycle returns the incoming write data instead of the stored value.
module iop_regfile
  import iop_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RADDR_W-1:0] ra1,
  input  logic [RADDR_W-1:0] ra2,
  output logic [DATA_W-1:0]  rd1,
  output logic [DATA_W-1:0]  rd2,
  input  logic               we,
  input  logic [RADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]  wd
);

  logic [DATA_W-1:0] mem [8];

  // Storage: cleared on reset, written on the clock edge when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Read ports, with optional same-cycle write bypass.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
`ifdef IOP_ID_BYPASS_EN
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
`else
    if (ra1 != '0) rd1 = mem[ra1];
    if (ra2 != '0) rd2 = mem[ra2];
`endif
  end

endmodule

// File: rtl/iop_id_stage.sv
// IOP instruction-decode stage: decodes a 16-bit instruction, reads operands
// from the register file and registers a one-hot ALU control bundle behind a
// valid/ready handshake. flush kills both the held and the incoming bundle.
// Build option IOP_ID_BYPASS_EN enables write-to-read bypass in iop_regfile.
module iop_id_stage
  import iop_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic                wb_en,
  input  logic [RADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   ds1,
  output logic [DATA_W-1:0]   ds2,
  output logic [DATA_W-1:0]   imm,
  output logic                alu_add,
  output logic                alu_sub,
  output logic                alu_and,
  output logic                alu_or,
  output logic                alu_xor,
  output logic                alu_sr,
  output logic                alu_sl,
  output logic                alu_sra,
  output logic                alu_slt,
  output logic                alu_eq,
  output logic                alu_neq,
  output logic                unsign,
  output logic                bra,
  output logic [RADDR_W-1:0]  rd_addr,
  output logic                rd_we,
  output logic                illegal
);

  logic [3:0]         op;
  logic [RADDR_W-1:0] rd_f, rs1_f, rs2_f;
  logic [DATA_W-1:0]  imm8_f, rs1_data, rs2_data;

  ctrl_t             ctrl_next, ctrl_reg;
  logic [DATA_W-1:0] ds1_next, ds2_next, imm_next;
  logic [DATA_W-1:0] ds1_reg, ds2_reg, imm_reg;
  logic [RADDR_W-1:0] rd_addr_reg;
  logic              out_valid_reg;
  logic              transfer;

  assign op     = in_instr[15:12];
  assign rd_f   = in_instr[11:9];
  assign rs1_f  = in_instr[8:6];
  assign rs2_f  = in_instr[5:3];
  assign imm8_f = in_instr[7:0];

  iop_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1_f),
    .ra2   (rs2_f),
    .rd1   (rs1_data),
    .rd2   (rs2_data),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  assign in_ready = !out_valid_reg || out_ready;
  assign transfer = in_valid && in_ready && !flush;

  // Decode the incoming instruction into the next control/operand bundle.
  always_comb begin
    ctrl_next       = '0;
    ds1_next        = rs1_data;
    ds2_next        = rs2_data;
    imm_next        = '0;
    ctrl_next.rd_we = (op <= 4'hC) && (rd_f != '0);
    case (op)
      OP_ADD:  ctrl_next.alu_add = 1'b1;
      OP_SUB:  ctrl_next.alu_sub = 1'b1;
      OP_AND:  ctrl_next.alu_and = 1'b1;
      OP_OR:   ctrl_next.alu_or  = 1'b1;
      OP_XOR:  ctrl_next.alu_xor = 1'b1;
      OP_SRL:  begin ctrl_next.alu_sr = 1'b1; ctrl_next.unsign = 1'b1; end
      OP_SLL:  ctrl_next.alu_sl  = 1'b1;
      OP_SRA:  begin ctrl_next.alu_sr = 1'b1; ctrl_next.alu_sra = 1'b1; end
      OP_SLT:  ctrl_next.alu_slt = 1'b1;
      OP_EQ:   ctrl_next.alu_eq  = 1'b1;
      OP_NEQ:  ctrl_next.alu_neq = 1'b1;
      OP_SLTU: begin ctrl_next.alu_slt = 1'b1; ctrl_next.unsign = 1'b1; end
      OP_LI:   begin imm_next = imm8_f; ds1_next = '0; ds2_next = '0; end
      OP_BRA:  ctrl_next.bra = 1'b1;
      default: ctrl_next.illegal = 1'b1;
    endcase
  end

  // Output register: flush wins, then capture on transfer, then drain on consume.
  // Operands only change on capture; controls drop whenever the bundle goes invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
      ds1_reg       <= '0;
      ds2_reg       <= '0;
      imm_reg       <= '0;
      rd_addr_reg   <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
    end else if (transfer) begin
      out_valid_reg <= 1'b1;
      ctrl_reg      <= ctrl_next;
      ds1_reg       <= ds1_next;
      ds2_reg       <= ds2_next;
      imm_reg       <= imm_next;
      rd_addr_reg   <= rd_f;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
    end
  end

  assign out_valid = out_valid_reg;
  assign ds1       = ds1_reg;
  assign ds2       = ds2_reg;
  assign imm       = imm_reg;
  assign rd_addr   = rd_addr_reg;
  assign alu_add   = ctrl_reg.alu_add;
  assign alu_sub   = ctrl_reg.alu_sub;
  assign alu_and   = ctrl_reg.alu_and;
  assign alu_or    = ctrl_reg.alu_or;
  assign alu_xor   = ctrl_reg.alu_xor;
  assign alu_sr    = ctrl_reg.alu_sr;
  assign alu_sl    = ctrl_reg.alu_sl;
  assign alu_sra   = ctrl_reg.alu_sra;
  assign alu_slt   = ctrl_reg.alu_slt;
  assign alu_eq    = ctrl_reg.alu_eq;
  assign alu_neq   = ctrl_reg.alu_neq;
  assign unsign    = ctrl_reg.unsign;
  assign bra       = ctrl_reg.bra;
  assign rd_we     = ctrl_reg.rd_we;
  assign illegal   = ctrl_reg.illegal;

endmodule

// File: tb/tb_iop_id_stage.sv
// Directed testbench for iop_id_stage with hand-computed expectations.
// Controls are compared as one 13-bit vector:
// {add,sub,and,or,xor,sr,sl,sra,slt,eq,neq,unsign,bra}.
module tb_iop_id_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_instr;
  logic       wb_en;
  logic [2:0] wb_addr, rd_addr;
  logic [7:0] wb_data, ds1, ds2, imm;
  logic       alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_sr, alu_sl;
  logic       alu_sra, alu_slt, alu_eq, alu_neq, unsign, bra, rd_we, illegal;
  logic [12:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  assign ctl = {alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_sr, alu_sl,
                alu_sra, alu_slt, alu_eq, alu_neq, unsign, bra};

  always #5 clk = ~clk;

  iop_id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ds1(ds1), .ds2(ds2), .imm(imm),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and), .alu_or(alu_or),
    .alu_xor(alu_xor), .alu_sr(alu_sr), .alu_sl(alu_sl), .alu_sra(alu_sra),
    .alu_slt(alu_slt), .alu_eq(alu_eq), .alu_neq(alu_neq), .unsign(unsign),
    .bra(bra), .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (ctl !== 13'h0) begin n_err++; $display("FAIL reset_ctl: got %h expected 0", ctl); end
    n_cmp++; if ({ds1, ds2, imm} !== 24'h0) begin n_err++; $display("FAIL reset_operands: got %h expected 0", {ds1, ds2, imm}); end
    n_cmp++; if ({rd_addr, rd_we, illegal} !== 5'h0) begin n_err++; $display("FAIL reset_rd: got %h expected 0", {rd_addr, rd_we, illegal}); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    $display("txn reset done");
  endtask

  task automatic test_sub();
    wb_write(3'd2, 8'd5);
    wb_write(3'd3, 8'd3);
    in_valid = 1'b1; in_instr = 16'h1498;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid: got %b expected 1", out_valid); end
    n_cmp++; if (ctl !== 13'h0800) begin n_err++; $display("FAIL sub_ctl: got %h expected 0800", ctl); end
    n_cmp++; if ({ds1, ds2, imm} !== {8'd5, 8'd3, 8'd0}) begin n_err++; $display("FAIL sub_operands: got %h expected 050300", {ds1, ds2, imm}); end
    n_cmp++; if ({rd_addr, rd_we, illegal} !== {3'd2, 1'b1, 1'b0}) begin n_err++; $display("FAIL sub_rd: got %h/%b/%b expected 2/1/0", rd_addr, rd_we, illegal); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({ctl, rd_we} !== 14'h0) begin n_err++; $display("FAIL sub_drain_ctl: got %h expected 0", {ctl, rd_we}); end
    $display("txn SUB r2,r2,r3 ds1=%0d ds2=%0d", ds1, ds2);
  endtask

  task automatic test_li();
    in_valid = 1'b1; in_instr = 16'hC2A5;
    step();
    in_valid = 1'b0;
    n_cmp++; if (imm !== 8'hA5) begin n_err++; $display("FAIL li_imm: got %h expected a5", imm); end
    n_cmp++; if ({ds1, ds2} !== 16'h0) begin n_err++; $display("FAIL li_ds: got %h expected 0", {ds1, ds2}); end
    n_cmp++; if (ctl !== 13'h0) begin n_err++; $display("FAIL li_ctl: got %h expected 0", ctl); end
    n_cmp++; if ({out_valid, rd_we, rd_addr} !== {1'b1, 1'b1, 3'd1}) begin n_err++; $display("FAIL li_rd: got %b/%b/%0d expected 1/1/1", out_valid, rd_we, rd_addr); end
    step();
    $display("txn LI r1,0xA5");
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0A98;     // ADD r5,r2,r3
    step();
    in_instr = 16'h2CD0;                       // AND r6,r3,r2
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_cmp++; if ({out_valid, ctl, ds1, ds2, rd_addr} !== {1'b1, 13'h1000, 8'd5, 8'd3, 3'd5}) begin n_err++; $display("FAIL stall_hold[%0d]: got %b %h %h %h %0d", i, out_valid, ctl, ds1, ds2, rd_addr); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, ctl, ds1, ds2, rd_addr} !== {1'b1, 13'h0400, 8'd3, 8'd5, 3'd6}) begin n_err++; $display("FAIL stall_next: got %b %h %h %h %0d expected AND 3,5 r6", out_valid, ctl, ds1, ds2, rd_addr); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
    $display("txn stall 3 cycles then AND r6");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h4298;     // XOR r1,r2,r3
    step();
    n_cmp++; if ({out_valid, ctl} !== {1'b1, 13'h0100}) begin n_err++; $display("FAIL flush_setup: got %b %h expected 1 0100", out_valid, ctl); end
    in_instr = 16'h3E98; flush = 1'b1; out_ready = 1'b1;   // OR r7 must be dropped
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, ctl, rd_we, illegal} !== 16'h0) begin n_err++; $display("FAIL flush_kill: got %b %h %b expected all 0", out_valid, ctl, rd_we); end
    step();
    n_cmp++; if ({out_valid, ctl} !== 14'h0) begin n_err++; $display("FAIL flush_no_issue: got %b %h expected 0", out_valid, ctl); end
    $display("txn flush XOR/OR");
  endtask

  task automatic test_bypass();
    logic [7:0] exp_ds1;
`ifdef IOP_ID_BYPASS_EN
    exp_ds1 = 8'h7E;
`else
    exp_ds1 = 8'h11;
`endif
    wb_write(3'd4, 8'h11);
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h7E;
    in_valid = 1'b1; in_instr = 16'h0300;     // ADD r1,r4,r0
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({ds1, ds2} !== {exp_ds1, 8'h00}) begin n_err++; $display("FAIL bypass_ds1: got %h/%h expected %h/00", ds1, ds2, exp_ds1); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (ds1 !== 8'h7E) begin n_err++; $display("FAIL bypass_after: got %h expected 7e", ds1); end
    step();
    $display("txn same-cycle wb r4 ds1=%h", exp_ds1);
  endtask

  task automatic test_opcodes();
    logic [15:0] instr_t [9] = '{16'h7298, 16'hB298, 16'hE298, 16'h5298, 16'hD298,
                                 16'h0098, 16'h9298, 16'h8298, 16'hF298};
    logic [12:0] ctl_t   [9] = '{13'h00A0, 13'h0012, 13'h0000, 13'h0082, 13'h0001,
                                 13'h1000, 13'h0008, 13'h0010, 13'h0000};
    logic        we_t    [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ill_t   [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = instr_t[i];
      step();
      in_valid = 1'b0;
      n_cmp++; if ({out_valid, ctl, rd_we, illegal, imm} !== {1'b1, ctl_t[i], we_t[i], ill_t[i], 8'h00}) begin n_err++; $display("FAIL opcode_%h: got v=%b ctl=%h we=%b ill=%b imm=%h expected ctl=%h we=%b ill=%b", instr_t[i][15:12], out_valid, ctl, rd_we, illegal, imm, ctl_t[i], we_t[i], ill_t[i]); end
      if (!ill_t[i]) begin
        n_cmp++; if (ds1 !== 8'd5) begin n_err++; $display("FAIL opcode_%h_ds1: got %h expected 05", instr_t[i][15:12], ds1); end
      end
      step();
      $display("txn opcode %h ctl=%h", instr_t[i][15:12], ctl_t[i]);
    end
  endtask

  task automatic test_r0();
    wb_write(3'd0, 8'hFF);
    in_valid = 1'b1; in_instr = 16'h0200;     // ADD r1,r0,r0
    step();
    in_valid = 1'b0;
    n_cmp++; if ({ds1, ds2} !== 16'h0) begin n_err++; $display("FAIL r0_read: got %h expected 0", {ds1, ds2}); end
    step();
    $display("txn R0 write ignored");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h1498;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, ctl, rd_we} !== 15'h0) begin n_err++; $display("FAIL async_reset: got %b %h %b expected 0", out_valid, ctl, rd_we); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1;                           // SUB r2,r2,r3 after regs cleared
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, ctl, ds1, ds2} !== {1'b1, 13'h0800, 8'd0, 8'd0}) begin n_err++; $display("FAIL reset_regs_cleared: got %b %h %h %h expected 1 0800 00 00", out_valid, ctl, ds1, ds2); end
    step();
    $display("txn reset mid-transfer");
  endtask

  initial begin
    test_reset();
    test_sub();
    test_li();
    test_stall();
    test_flush();
    test_bypass();
    test_opcodes();
    test_r0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
